// File: rtl/pipe_dmem_responder.sv
// pipe_dmem_responder: word-wide data memory answering req/ack requests after programmable wait states
module pipe_dmem_responder #(
    parameter int ADDR_WIDTH  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(WAIT_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  we_q, we_d, bad_q, bad_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           mem_d [DEPTH];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        bad_d   = bad_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: if (req) begin
                we_d    = we;
                idx_d   = addr[ADDR_WIDTH+1:2];
                wdata_d = wdata;
                bad_d   = (addr[1:0] != 2'b00) || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);
                state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
                cnt_d   = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
            end
            WAIT: begin
                state_d = cnt_q == '0 ? RESP : WAIT;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                if (we_q && !bad_q) mem_d[idx_q] = wdata_q;
            end
            default: state_d = IDLE;
        endcase
        // rdata is loaded on the edge entering RESP so it is a flop during the ack cycle
        if (state_d == RESP) rdata_d = bad_d ? '0 : (we_d ? rdata_q : mem_q[idx_d]);
    end
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end
    assign ack   = state_q == RESP;
    assign err   = ack && bad_q;
    assign busy  = state_q != IDLE;
    assign rdata = rdata_q;
endmodule

// File: tb/tb_pipe_dmem_responder.sv
// tb_pipe_dmem_responder: scoreboard bench driving a 2-wait-state and a 0-wait-state responder
module tb_pipe_dmem_responder;
    localparam int AW = 6;
    localparam int W0 = 2;
    localparam int W1 = 0;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [1:0]  clrn, req, we, ack, err, busy;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    pipe_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u0 (
        .clk(clk), .clrn(clrn[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));
    pipe_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u1 (
        .clk(clk), .clrn(clrn[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));
    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          cyc;
    } exp_t;
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc [2];
    logic [31:0] mdl [2][2**AW];
    logic [31:0] last [2];
    logic [31:0] shown [2];
    bit          b2b [2];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic clear_model(input int k);
        for (int i = 0; i < 2**AW; i++) mdl[k][i] = '0;
        last[k]  = '0;
        shown[k] = '0;
        b2b[k]   = 1'b0;
    endtask
    always @(posedge clk) begin
        cyc[0]++;
        cyc[1]++;
    end
    task automatic mon(input int k);
        exp_t e;
        int   n;
        if (clrn[k]) return;
        if (ack[k]) begin
            n = k == 0 ? q0.size() : q1.size();
            if (n == 0) chk("spurious_ack", 32'(ack[k]), 32'd0);
            else begin
                if (k == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk("rdata", rdata[k], e.rd);
                chk("err", 32'(err[k]), 32'(e.er));
                chk("latency", 32'(cyc[k]), 32'(e.cyc));
                chk("busy_ack", 32'(busy[k]), 32'd1);
                shown[k] = e.rd;
            end
        end else begin
            chk("err_idle", 32'(err[k]), 32'd0);
            chk("rdata_hold", rdata[k], shown[k]);
        end
    endtask
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end
    task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d, input bit keep);
        exp_t e;
        bit   bad;
        int   n;
        if (!b2b[k]) @(negedge clk);
        bad = (a[1:0] != 2'b00) || (a >= (32'd4 << AW));
        e.er = bad;
        e.rd = bad ? 32'd0 : (w ? last[k] : mdl[k][a[AW+1:2]]);
        if (w && !bad) mdl[k][a[AW+1:2]] = d;
        last[k] = e.rd;
        e.cyc = cyc[k] + 1 + (k == 0 ? W0 : W1) + (b2b[k] ? 1 : 0);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
        req[k] = 1'b1;
        we[k] = w;
        addr[k] = a;
        wdata[k] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[k] && n < 20);
        if (!ack[k]) chk("ack_timeout", 32'(ack[k]), 32'd1);
        b2b[k] = keep;
        if (!keep) req[k] = 1'b0;
    endtask
    task automatic rst_txn(input int k, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req[k] = 1'b1;
        we[k] = 1'b1;
        addr[k] = a;
        wdata[k] = d;
        @(posedge clk);
        #1 clrn[k] = 1'b1;
        #1;
        chk("busy_rst", 32'(busy[k]), 32'd0);
        chk("ack_rst", 32'(ack[k]), 32'd0);
        chk("rdata_rst", rdata[k], 32'd0);
        req[k] = 1'b0;
        clear_model(k);
        @(negedge clk);
        @(negedge clk);
        clrn[k] = 1'b0;
        repeat (4) @(negedge clk);
    endtask
    initial begin
        clrn = 2'b11;
        req = '0;
        we = '0;
        for (int k = 0; k < 2; k++) begin
            addr[k] = '0;
            wdata[k] = '0;
            cyc[k] = 0;
            clear_model(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_err", 32'(err[k]), 32'd0);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_rdata", rdata[k], 32'd0);
        end
        clrn = 2'b00;
        for (int k = 0; k < 2; k++) begin
            txn(k, 0, 32'h00, 32'h0, 0);
            txn(k, 1, 32'h10, 32'hDEADBEEF, 0);
            txn(k, 0, 32'h10, 32'h0, 0);
            txn(k, 1, 32'h13, 32'h55555555, 0);
            txn(k, 0, 32'h10, 32'h0, 0);
            txn(k, 0, 32'h100, 32'h0, 0);
            txn(k, 1, 32'h100, 32'h0BADF00D, 0);
            txn(k, 0, 32'h00, 32'h0, 0);
            txn(k, 0, 32'h10, 32'h0, 0);
            txn(k, 1, 32'h04, 32'h12345678, 1);
            txn(k, 0, 32'h04, 32'h0, 0);
            for (int i = 0; i < 24; i++)
                txn(k, 1'($urandom_range(0, 1)),
                    (32'($urandom_range(0, 70)) << 2) | ($urandom_range(0, 7) == 0 ? 32'd1 : 32'd0),
                    $urandom, i < 23 && $urandom_range(0, 3) == 0);
            rst_txn(k, 32'h08, 32'hA5A5A5A5);
            txn(k, 0, 32'h08, 32'h0, 0);
            txn(k, 0, 32'h10, 32'h0, 0);
        end
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_dmem_responder.md
Name: pipe_dmem_responder

Overview:
Data-memory responder for the pipelined CPU. It sits on the far side of the MEM-stage load/store interface and answers one word-sized read or write request at a time using a req/ack handshake. Wait states are programmable, and misaligned or out-of-range accesses are reported as errors. It lets the pipeline be verified against a slow memory instead of a combinational one.

Parameters:
ADDR_WIDTH, 6, number of word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words.
WAIT_CYCLES, 2, cycles spent in WAIT between accepting a request and acking it; 0 is legal.

Ports:
clk  input  1  clock; all state changes on the rising edge.
clrn  input  1  reset; asynchronous, active-high.
req  input  1  request valid; the requester holds it high until it samples ack.
we  input  1  1 = write, 0 = read; sampled with req.
addr  input  32  byte address; sampled with req.
wdata  input  32  write data; sampled with req.
ack  output  1  one-cycle response strobe.
rdata  output  32  read data; valid while ack=1 for a successful read.
err  output  1  error flag; valid only while ack=1.
busy  output  1  high from the cycle after acceptance up to and including the ack cycle.

Behaviour:
- Reset (clrn=1, asynchronous, any state):
  - state=IDLE; ack=0, err=0, busy=0, rdata=0; wait counter=0.
  - All memory words cleared to 0.
- Reset mid-transaction: the transaction is abandoned, no write is performed and no ack is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1, latch we, addr and wdata, and compute the error flag.
  - Error = (addr[1:0]!=0) OR (addr[31:ADDR_WIDTH+2]!=0).
  - Next state: WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), otherwise RESP.
  - If req=0, stay in IDLE.
- WAIT:
  - Counter decrements each cycle; go to RESP when it reaches 0.
  - req, we, addr and wdata are ignored; the latched copies are used.
- RESP (exactly one cycle), then always IDLE:
  - ack=1, err=latched error flag.
  - Successful write: mem[addr[ADDR_WIDTH+1:2]] <= wdata on the edge ending RESP.
  - Successful read: rdata=mem[addr[ADDR_WIDTH+1:2]].
  - Error: no write, rdata=0.
- ack, err and rdata are registered; none is combinational from any input.
- Latency: request accepted at edge E, ack high during the cycle after edge E+WAIT_CYCLES. Total = WAIT_CYCLES+1 cycles from acceptance to ack.
- Handshake rules:
  - The requester drops req in the cycle after it samples ack=1.
  - If req is still high in the IDLE cycle after RESP, it is accepted as a new request; back-to-back requests are legal.
- req dropping while busy does not abort the transaction; the ack is still issued.
- rdata holds its last value outside read acks, except that it is forced to 0 on error acks and by reset.
- err=0 whenever ack=0.
- A write followed immediately by a read of the same word returns the new data (the write commits before the next acceptance).
- Address wrap: none. Out-of-range addresses are errors, never aliased.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> each ack arrives 3 cycles after acceptance (WAIT_CYCLES=2); read returns rdata=0xDEADBEEF, err=0.
- Read addr 0x00 right after reset -> rdata=0x00000000, err=0.
- Write to addr 0x13 (misaligned), then read addr 0x10 -> the write acks with err=1 and rdata=0; the read still returns 0xDEADBEEF.
- Read addr 0x100 with ADDR_WIDTH=6 -> ack with err=1, rdata=0; no memory word changes.
- Back-to-back: write 0x12345678 to 0x04 with req held through the ack, then immediately read 0x04 -> second accept in the IDLE cycle after RESP; rdata=0x12345678.
- Assert clrn during WAIT of a write of 0xA5A5A5A5 to 0x08 -> no ack, busy=0 immediately; a later read of 0x08 returns 0. Repeat with WAIT_CYCLES=0 -> ack 1 cycle after acceptance.
